// File: rtl/ex_issue_ctrl_if.sv
// ID <-> EX issue-register bundle for ex_issue_ctrl.
// The master modport is the decode side; the slave modport is the issue controller.
interface ex_issue_ctrl_if #(
   parameter int unsigned EX_W  = 7,
   parameter int unsigned WB_W  = 4,
   parameter int unsigned CNT_W = 3
);
   logic             id_valid;
   logic [EX_W-1:0]  id_EX;
   logic [WB_W-1:0]  id_WB;
   logic             flush;
   logic             exc;
   logic [EX_W-1:0]  ex_EX;
   logic [WB_W-1:0]  ex_WB;
   logic             ex_valid;
   logic             stall_id;
   logic             result_valid;
   logic [CNT_W-1:0] lat_cnt;
   logic             exc_kill;

   modport master (
      output id_valid, id_EX, id_WB, flush, exc,
      input  ex_EX, ex_WB, ex_valid, stall_id, result_valid, lat_cnt, exc_kill
   );

   modport slave (
      input  id_valid, id_EX, id_WB, flush, exc,
      output ex_EX, ex_WB, ex_valid, stall_id, result_valid, lat_cnt, exc_kill
   );
endinterface

// File: rtl/ex_issue_ctrl.sv
// ID/EX issue register with multi-cycle occupancy counter and ID stall generation.
// Optional macro EXC_ABORT_EN: an FP divide-by-zero exception aborts an in-flight fdiv.
module ex_issue_ctrl #(
   parameter int unsigned EX_W  = 7,
   parameter int unsigned WB_W  = 4,
   parameter int unsigned CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   ex_issue_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      StIdle,
      StHold,
      StBusy
   } state_e;

   state_e           state_q, state_d;
   logic [EX_W-1:0]  ex_q, ex_d;
   logic [WB_W-1:0]  wb_q, wb_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stall;
   logic             accept;
   logic [CNT_W-1:0] lat;

   function automatic logic [CNT_W-1:0] lat_decode(input logic [EX_W-1:0] ex);
      logic [CNT_W-1:0] l;
      l = '0;
      if (ex[0]) begin
         if (ex[4:1] == 4'b0011) l = CNT_W'(7);
      end else if (ex[4]) begin
         unique case (ex[3:1])
            3'b000, 3'b001, 3'b011, 3'b100, 3'b110: l = CNT_W'(6);
            3'b101:                                 l = CNT_W'(4);
            default:                                l = '0;
         endcase
      end
      return l;
   endfunction

   assign stall  = (state_q == StBusy);
   assign lat    = lat_decode(bus.id_EX);
   assign accept = bus.id_valid & ~stall & ~bus.flush;

`ifdef EXC_ABORT_EN
   logic kill_q, kill_d;
   logic is_fdiv;
   assign is_fdiv = ~ex_q[0] & ex_q[4] & (ex_q[3:1] == 3'b110);
`else
   logic unused_exc;
   assign unused_exc = bus.exc;
`endif

   always_comb begin
      state_d = state_q;
      ex_d    = ex_q;
      wb_d    = wb_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
`ifdef EXC_ABORT_EN
      kill_d  = 1'b0;
`endif
      if (bus.flush) begin
         // Flush wins over everything, including a same-cycle accept or exception.
         state_d = StIdle;
         ex_d    = '0;
         wb_d    = '0;
         valid_d = 1'b0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StIdle, StHold: begin
               if (accept) begin
                  ex_d    = bus.id_EX;
                  wb_d    = bus.id_WB;
                  valid_d = 1'b1;
                  cnt_d   = lat;
                  state_d = (lat == '0) ? StHold : StBusy;
               end else if (state_q == StHold) begin
                  state_d = StIdle;
                  ex_d    = '0;
                  wb_d    = '0;
                  valid_d = 1'b0;
                  cnt_d   = '0;
               end
            end
            StBusy: begin
`ifdef EXC_ABORT_EN
               if (bus.exc && is_fdiv) begin
                  state_d = StIdle;
                  ex_d    = '0;
                  wb_d    = '0;
                  valid_d = 1'b0;
                  cnt_d   = '0;
                  kill_d  = 1'b1;
               end else
`endif
               if (cnt_q <= CNT_W'(1)) begin
                  cnt_d   = '0;
                  state_d = StHold;
               end else begin
                  cnt_d   = cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_d = StIdle;
               ex_d    = '0;
               wb_d    = '0;
               valid_d = 1'b0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         ex_q    <= '0;
         wb_q    <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ex_q    <= ex_d;
         wb_q    <= wb_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef EXC_ABORT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) kill_q <= 1'b0;
      else     kill_q <= kill_d;
   end
   assign bus.exc_kill = kill_q;
`else
   assign bus.exc_kill = 1'b0;
`endif

   // WB is only released on the completion cycle.
   assign bus.ex_WB        = (state_q == StHold) ? wb_q : '0;
   assign bus.ex_EX        = ex_q;
   assign bus.ex_valid     = valid_q;
   assign bus.stall_id     = stall;
   assign bus.result_valid = (state_q == StHold);
   assign bus.lat_cnt      = cnt_q;

endmodule
